// File: rtl/rex_sprite_engine.sv
// Player sprite for the VGA runner: tick-driven jump physics, wrap-around X motion, registered renderer.
// Define REX_DUCK_EN to add the DUCK state and second bitmap frame (ROM rows SPRITE_H..2*SPRITE_H-1).
module rex_sprite_engine #(
    parameter int          SPRITE_W     = 23,
    parameter int          SPRITE_H     = 47,
    parameter int          ROW_AW       = 7,
    parameter int          GROUND_Y     = 447,
    parameter int          X_MIN        = 150,
    parameter int          X_MAX        = 800,
    parameter int          X_STEP       = 2,
    parameter int          TICK_DIV     = 5,
    parameter int          JUMP_V       = 12,
    parameter int          GRAVITY      = 1,
    parameter logic [11:0] SPRITE_COLOR = 12'hF00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bright,
    input  logic                up,
    input  logic                down,
    input  logic                left,
    input  logic                right,
    input  logic [9:0]          hCount,
    input  logic [9:0]          vCount,
    output logic [ROW_AW-1:0]   sprite_addr,
    input  logic [SPRITE_W-1:0] sprite_row,
    output logic [11:0]         rgb,
    output logic [11:0]         background,
    output logic [9:0]          xpos,
    output logic [9:0]          ytop,
    output logic                airborne
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_GROUND = 3'd0;
    localparam logic [2:0] S_RISE   = 3'd1;
    localparam logic [2:0] S_FALL   = 3'd2;
    localparam logic [2:0] S_LAND   = 3'd3;
`ifdef REX_DUCK_EN
    localparam logic [2:0] S_DUCK   = 3'd4;
`endif

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [7:0]    height;
    logic [7:0]    vel;
    logic [9:0]    h_sum;
    logic [7:0]    vel_dec;
    logic [10:0]   x_inc;
    logic [9:0]    rel_x;
    logic [9:0]    rel_y;
    logic          duck;
    logic          pix;
    logic          hit;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // Height is unsigned, vel signed: sign-extend vel so a descent past ground shows as negative.
    assign h_sum   = {2'b00, height} + {{2{vel[7]}}, vel};
    assign vel_dec = vel - 8'(GRAVITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_GROUND;
            height <= '0;
            vel    <= '0;
        end else if (tick) begin
            case (state)
                S_GROUND: begin
                    if (up) begin
                        state <= S_RISE;
                        vel   <= 8'(JUMP_V);
                    end
`ifdef REX_DUCK_EN
                    else if (down) state <= S_DUCK;
`endif
                end
                S_RISE, S_FALL: begin
                    if (h_sum[9] || h_sum == '0) begin
                        state  <= S_LAND;
                        height <= '0;
                        vel    <= '0;
                    end else begin
                        height <= h_sum[7:0];
                        vel    <= vel_dec;
                        state  <= (vel_dec[7] || vel_dec == '0) ? S_FALL : S_RISE;
                    end
                end
                S_LAND: state <= S_GROUND;
`ifdef REX_DUCK_EN
                S_DUCK: if (!down) state <= S_GROUND;
`endif
                default: state <= S_GROUND;
            endcase
        end
    end

    assign x_inc = {1'b0, xpos} + 11'(X_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos <= 10'd200;
        end else if (tick) begin
            if (right && !left)
                xpos <= (x_inc >= 11'(X_MAX)) ? 10'(X_MIN) : x_inc[9:0];
            else if (left && !right)
                xpos <= (xpos <= 10'(X_MIN)) ? 10'(X_MAX) : xpos - 10'(X_STEP);
        end
    end

`ifdef REX_DUCK_EN
    assign duck = (state == S_DUCK);
`else
    assign duck = 1'b0;
`endif

    assign airborne    = (state == S_RISE) || (state == S_FALL);
    assign ytop        = 10'(GROUND_Y - SPRITE_H) - {2'b00, height};
    assign rel_x       = hCount - xpos;
    assign rel_y       = vCount - ytop;
    assign sprite_addr = rel_y[ROW_AW-1:0] + (duck ? ROW_AW'(SPRITE_H) : '0);

    // Bit SPRITE_W-1 of the ROM row is the leftmost pixel.
    always_comb begin
        pix = 1'b0;
        for (int i = 0; i < SPRITE_W; i++)
            if (rel_x == 10'(i)) pix = sprite_row[SPRITE_W-1-i];
    end

    assign hit = (rel_x < 10'(SPRITE_W)) && (rel_y < 10'(SPRITE_H)) && pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb        <= 12'h000;
            background <= 12'hFFF;
        end else begin
            rgb <= !bright ? 12'h000 : (hit ? SPRITE_COLOR : background);
            if (right)     background <= 12'hFF0;
            else if (left) background <= 12'h0FF;
            else if (down) background <= 12'h0F0;
            else if (up)   background <= 12'h00F;
        end
    end
endmodule

// File: tb/tb_rex_sprite_engine.sv
// Randomised bench for rex_sprite_engine against a per-tick integer model of jump, wrap and render rules.
module tb_rex_sprite_engine;
    localparam int SW = 23, SH = 47, GY = 447, XMIN = 150, XMAX = 800, XSTEP = 2;
    localparam int TD = 5, JV = 12, GR = 1;
`ifdef REX_DUCK_EN
    localparam bit DUCK_EN = 1'b1;
`else
    localparam bit DUCK_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b1, bright = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [9:0]  hCount = '0, vCount = '0;
    logic [6:0]  sprite_addr;
    logic [22:0] sprite_row;
    logic [11:0] rgb, background;
    logic [9:0]  xpos, ytop;
    logic        airborne;
    logic [22:0] rom [0:127];

    assign sprite_row = rom[sprite_addr];

    rex_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .bright(bright),
        .up(up), .down(down), .left(left), .right(right),
        .hCount(hCount), .vCount(vCount),
        .sprite_addr(sprite_addr), .sprite_row(sprite_row),
        .rgb(rgb), .background(background),
        .xpos(xpos), .ytop(ytop), .airborne(airborne)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integers, updated once per clock.
    typedef enum {M_GROUND, M_RISE, M_FALL, M_LAND, M_DUCK} mstate_t;
    mstate_t m_st;
    int m_cnt, m_x, m_h, m_v, m_bg, m_rgb;
    bit m_ticked;

    function automatic int m_top();
        return GY - SH - m_h;
    endfunction

    function automatic int m_addr();
        int ry = (int'(vCount) - m_top()) & 1023;
        return (ry + ((m_st == M_DUCK) ? SH : 0)) & 127;
    endfunction

    function automatic bit m_hit();
        int rx = (int'(hCount) - m_x) & 1023;
        int ry = (int'(vCount) - m_top()) & 1023;
        logic [22:0] row;
        if (rx >= SW || ry >= SH) return 1'b0;
        row = rom[m_addr()];
        return row[SW-1-rx];
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_x = 200; m_h = 0; m_v = 0; m_st = M_GROUND;
        m_bg = 'hFFF; m_rgb = 0; m_ticked = 1'b0;
    endfunction

    function automatic void model_clk();
        m_rgb = !bright ? 0 : (m_hit() ? 'hF00 : m_bg);
        if (right)     m_bg = 'hFF0;
        else if (left) m_bg = 'h0FF;
        else if (down) m_bg = 'h0F0;
        else if (up)   m_bg = 'h00F;
        m_ticked = (m_cnt == TD - 1);
        m_cnt    = m_ticked ? 0 : m_cnt + 1;
        if (m_ticked) begin
            case (m_st)
                M_GROUND: if (up) begin m_st = M_RISE; m_v = JV; end
                          else if (DUCK_EN && down) m_st = M_DUCK;
                M_RISE, M_FALL:
                    if (m_h + m_v <= 0) begin m_st = M_LAND; m_h = 0; m_v = 0; end
                    else begin
                        m_h  = m_h + m_v;
                        m_v  = m_v - GR;
                        m_st = (m_v <= 0) ? M_FALL : M_RISE;
                    end
                M_LAND: m_st = M_GROUND;
                M_DUCK: if (!down) m_st = M_GROUND;
                default: m_st = M_GROUND;
            endcase
            if (right && !left) begin
                m_x = m_x + XSTEP;
                if (m_x >= XMAX) m_x = XMIN;
            end else if (left && !right) begin
                m_x = (m_x <= XMIN) ? XMAX : m_x - XSTEP;
            end
        end
    endfunction

    task automatic check_all();
        chk("xpos", int'(xpos), m_x);
        chk("ytop", int'(ytop), m_top());
        chk("airborne", int'(airborne), int'(m_st == M_RISE || m_st == M_FALL));
        chk("rgb", int'(rgb), m_rgb);
        chk("background", int'(background), m_bg);
        chk("sprite_addr", int'(sprite_addr), m_addr());
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clk();
        #1;
        check_all();
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!m_ticked && k < TD + 2);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_xpos", int'(xpos), 200);
        chk("rst_ytop", int'(ytop), 400);
        chk("rst_bg", int'(background), 'hFFF);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_air", int'(airborne), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int jt[6] = '{1, 2, 3, 12, 13, 25};
    int jy[6] = '{388, 377, 367, 322, 322, 400};

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 23'($urandom);
        rom[0][22] = 1'b1;
        rom[46][0] = 1'b1;
        model_reset();
        do_reset();

        // Render at the sprite corners and just outside.
        bright = 1'b1; hCount = 10'd200; vCount = 10'd400;
        cyc(); chk("hit_00", int'(rgb), 'hF00);
        bright = 1'b0;
        cyc(); chk("dark", int'(rgb), 0);
        bright = 1'b1; hCount = 10'd199;
        cyc(); chk("miss_left", int'(rgb), 'hFFF);
        hCount = 10'd222; vCount = 10'd446;
        cyc(); chk("hit_corner", int'(rgb), 'hF00);
        hCount = 10'd223;
        cyc(); chk("miss_right", int'(rgb), 'hFFF);
        hCount = 10'd222; vCount = 10'd447;
        cyc(); chk("miss_below", int'(rgb), 'hFFF);

        // Full jump trajectory.
        up = 1'b1; wait_tick(); up = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            wait_tick();
            for (int j = 0; j < 6; j++)
                if (jt[j] == k) chk($sformatf("jump_t%0d", k), int'(ytop), jy[j]);
            if (k == 12) chk("air_apex", int'(airborne), 1);
            if (k == 25) chk("air_land", int'(airborne), 0);
        end
        wait_tick();

        // Reset at height 50 during the rise, then a fresh jump.
        up = 1'b1; wait_tick(); up = 1'b0;
        repeat (5) wait_tick();
        chk("h50_ytop", int'(ytop), 350);
        do_reset();
        up = 1'b1; wait_tick(); up = 1'b0;
        wait_tick(); chk("rejump", int'(ytop), 388);
        repeat (26) wait_tick();

        // Horizontal wrap both ways and both-held hold.
        do_reset();
        left = 1'b1;
        for (int k = 0; k < 40 && m_x != XMIN; k++) wait_tick();
        wait_tick(); chk("wrap_left", int'(xpos), 800);
        wait_tick(); chk("at_798", int'(xpos), 798);
        left = 1'b0; right = 1'b1;
        wait_tick(); chk("wrap_right", int'(xpos), 150);
        left = 1'b1;
        wait_tick(); chk("both_hold", int'(xpos), 150);
        left = 1'b0; right = 1'b0;

        // Ducking selects the second ROM frame when enabled.
        do_reset();
        down = 1'b1; wait_tick();
        hCount = xpos; vCount = 10'd403; #1;
`ifdef REX_DUCK_EN
        chk("duck_addr", int'(sprite_addr), 50);
        up = 1'b1; wait_tick(); wait_tick();
        chk("duck_up_air", int'(airborne), 0);
        chk("duck_up_ytop", int'(ytop), 400);
        up = 1'b0; down = 1'b0; wait_tick(); #1;
        chk("unduck_addr", int'(sprite_addr), 3);
`else
        chk("nodk_addr", int'(sprite_addr), 3);
        down = 1'b0;
`endif

        // Random buttons, raster positions around the sprite and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if (n % 16 == 0) begin
                up    = ($urandom_range(0, 99) < 20);
                down  = ($urandom_range(0, 99) < 30);
                left  = ($urandom_range(0, 99) < 35);
                right = ($urandom_range(0, 99) < 35);
            end
            bright = ($urandom_range(0, 3) != 0);
            hCount = 10'(m_x + int'($urandom_range(0, 30)) - 4);
            vCount = 10'(m_top() + int'($urandom_range(0, 55)) - 4);
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
